// File: rtl/oled_scan_serializer.sv
// Raster scanner and RGB565 serializer for the 96x64 OLED pixel path.
// Walks x/y across the panel, latches the scene generator's pixel in a
// single FETCH cycle, then shifts it out MSB-first on sclk/sdata (mode 0)
// with cs_n held low for the whole frame.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | link quiet, cs_n high; waits for enable to start a frame
// FETCH | x/y stable, pixel_data valid; latch it and preload first bit
// SHIFT | 16 sclk periods; advance raster on the 16th falling edge
module oled_scan_serializer #(
    parameter int WIDTH   = 96,
    parameter int HEIGHT  = 64,
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] pixel_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic        sclk,
    output logic        sdata,
    output logic        cs_n,
    output logic        frame_begin,
    output logic        busy
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0]       Y_LAST   = 6'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      shreg, shreg_nxt;
    logic [4:0]       bit_cnt, bit_cnt_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [6:0]       x_nxt;
    logic [5:0]       y_nxt;
    logic             sclk_nxt, sdata_nxt, cs_n_nxt, frame_begin_nxt, busy_nxt;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt       = state;
        shreg_nxt       = shreg;
        bit_cnt_nxt     = bit_cnt;
        div_cnt_nxt     = div_cnt;
        x_nxt           = x;
        y_nxt           = y;
        sclk_nxt        = sclk;
        sdata_nxt       = sdata;
        cs_n_nxt        = cs_n;
        frame_begin_nxt = 1'b0;

        case (state)
            IDLE: begin
                cs_n_nxt = 1'b1;
                sclk_nxt = 1'b0;
                if (enable) begin
                    state_nxt       = FETCH;
                    x_nxt           = '0;
                    y_nxt           = '0;
                    frame_begin_nxt = 1'b1;
                end
            end

            FETCH: begin
                shreg_nxt   = pixel_data;
                sdata_nxt   = pixel_data[15];
                cs_n_nxt    = 1'b0;
                sclk_nxt    = 1'b0;
                bit_cnt_nxt = '0;
                div_cnt_nxt = DIV_LOAD;
                state_nxt   = SHIFT;
            end

            SHIFT: begin
                if (div_cnt == '0) begin
                    div_cnt_nxt = DIV_LOAD;
                    sclk_nxt    = ~sclk;
                    // sclk currently high, so this toggle is a falling edge
                    if (sclk) begin
                        if (bit_cnt == 5'd15) begin
                            state_nxt = FETCH;
                            if (x < X_LAST) begin
                                x_nxt = x + 7'd1;
                            end else begin
                                x_nxt = '0;
                                if (y < Y_LAST) begin
                                    y_nxt = y + 6'd1;
                                end else begin
                                    // End of frame: only here may the stream stop
                                    y_nxt = '0;
                                    if (enable) begin
                                        frame_begin_nxt = 1'b1;
                                    end else begin
                                        state_nxt = IDLE;
                                        cs_n_nxt  = 1'b1;
                                    end
                                end
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 5'd1;
                            shreg_nxt   = {shreg[14:0], 1'b0};
                            sdata_nxt   = shreg[14];
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cs_n_nxt  = 1'b1;
                sclk_nxt  = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers; reset discards any partial pixel at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            x           <= '0;
            y           <= '0;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            cs_n        <= 1'b1;
            frame_begin <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            div_cnt     <= div_cnt_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            sclk        <= sclk_nxt;
            sdata       <= sdata_nxt;
            cs_n        <= cs_n_nxt;
            frame_begin <= frame_begin_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_oled_scan_serializer.sv
// Bench for oled_scan_serializer on a small 5x3 raster with CLK_DIV=2.
module tb_oled_scan_serializer;

    localparam int W     = 5;
    localparam int H     = 3;
    localparam int CD    = 2;
    localparam int NPIX  = W * H;
    localparam int PIX   = 1 + 32 * CD;
    localparam int FRAME = NPIX * PIX;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pixel_data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        sclk, sdata, cs_n, frame_begin, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] pix_tab [NPIX];

    oled_scan_serializer #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_data(pixel_data),
        .x(x), .y(y), .sclk(sclk), .sdata(sdata), .cs_n(cs_n),
        .frame_begin(frame_begin), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scene generator stand-in: word for the current raster position.
    always_comb pixel_data = pix_tab[(int'(y) * W + int'(x)) % NPIX];

    // Serial receiver: sample sdata on every sclk rise, assemble words.
    int          cyc = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_sdata = 1'b0;
    int          bitn = 0;
    logic [15:0] acc = '0;
    logic [15:0] rx_q[$];
    int          fb_q[$];
    int          sdata_viol = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            bitn = 0;
            acc = '0;
            prev_sclk = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                acc = {acc[14:0], sdata};
                bitn++;
                if (bitn == 16) begin
                    rx_q.push_back(acc);
                    bitn = 0;
                end
            end
            if (sclk && prev_sclk && sdata !== prev_sdata) sdata_viol++;
            if (frame_begin) fb_q.push_back(cyc);
            prev_sclk = sclk;
            prev_sdata = sdata;
        end
    end

    task automatic restart();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rx_q.delete();
        fb_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [18:0] exp_rst;
        int          k;
        exp_rst = {7'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({x, y, sclk, sdata, cs_n, frame_begin, busy} !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h",
                     {x, y, sclk, sdata, cs_n, frame_begin, busy}, exp_rst);
        end
        enable = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({busy, frame_begin, cs_n} !== 3'b001) begin
            n_fail++;
            $display("FAIL enable_in_reset: busy/fb/cs_n got %b expected 001",
                     {busy, frame_begin, cs_n});
        end
        rst_n = 1'b1;
        k = 0;
        while (!(x == 7'd2 && sclk === 1'b1) && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 400) begin
            n_fail++;
            $display("FAIL reach_mid_shift: timeout after %0d cycles, expected x=2 with sclk high", k);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({x, y, sclk, sdata, cs_n, frame_begin, busy} !== exp_rst) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h",
                     {x, y, sclk, sdata, cs_n, frame_begin, busy}, exp_rst);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pattern();
        int k;
        for (int i = 0; i < NPIX; i++) pix_tab[i] = 16'hA55A;
        restart();
        enable = 1'b1;
        k = 0;
        while (frame_begin !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 10) begin
            n_fail++;
            $display("FAIL frame_begin_start: timeout, frame_begin=%b expected 1", frame_begin);
        end
        @(negedge clk);
        n_checks++;
        if (frame_begin !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_begin_width: got %b one cycle later, expected 0", frame_begin);
        end
        n_checks++;
        if (cs_n !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cs_busy_active: cs_n=%b busy=%b expected 0 1", cs_n, busy);
        end
        k = 1;
        while (x !== 7'd1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== PIX) begin
            n_fail++;
            $display("FAIL pixel_period: got %0d cycles expected %0d", k, PIX);
        end
        n_checks++;
        if (rx_q.size() < 1 || rx_q[0] !== 16'hA55A) begin
            n_fail++;
            $display("FAIL a55a_bits: got %h (%0d words) expected a55a",
                     (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx, rx_q.size());
        end
    endtask

    task automatic test_scan_order();
        int k;
        for (int i = 0; i < NPIX; i++) pix_tab[i] = {3'b0, 6'(i / W), 7'(i % W)};
        restart();
        enable = 1'b1;
        k = 0;
        while (rx_q.size() < NPIX + 1 && k < FRAME + 2 * PIX + 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (rx_q.size() < NPIX + 1) begin
            n_fail++;
            $display("FAIL scan_words: got %0d words expected %0d", rx_q.size(), NPIX + 1);
        end
        for (int i = 0; i < rx_q.size() && i <= NPIX; i++) begin
            n_checks++;
            if (rx_q[i][6:0] !== 7'(i % W) || rx_q[i][12:7] !== 6'((i / W) % H)) begin
                n_fail++;
                $display("FAIL scan_order[%0d]: got x=%0d y=%0d expected x=%0d y=%0d",
                         i, rx_q[i][6:0], rx_q[i][12:7], i % W, (i / W) % H);
            end
        end
        n_checks++;
        if (fb_q.size() !== 2) begin
            n_fail++;
            $display("FAIL scan_wrap_frame_begin: got %0d pulses expected 2", fb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int k, cs_high;
        for (int i = 0; i < NPIX; i++) pix_tab[i] = 16'($urandom);
        restart();
        enable = 1'b1;
        k = 0;
        cs_high = 0;
        while (fb_q.size() < 3 && k < 3 * FRAME + 50) begin
            @(negedge clk);
            if (fb_q.size() > 0 && cs_n !== 1'b0) cs_high++;
            k++;
        end
        n_checks++;
        if (fb_q.size() < 3) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d frame_begin pulses expected 3", fb_q.size());
        end else begin
            for (int f = 1; f < 3; f++) begin
                n_checks++;
                if (fb_q[f] - fb_q[f-1] !== FRAME) begin
                    n_fail++;
                    $display("FAIL frame_period[%0d]: got %0d expected %0d",
                             f, fb_q[f] - fb_q[f-1], FRAME);
                end
            end
        end
        n_checks++;
        if (cs_high !== 0) begin
            n_fail++;
            $display("FAIL cs_n_continuous: high for %0d cycles expected 0", cs_high);
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] !== pix_tab[i % NPIX]) begin
                n_fail++;
                $display("FAIL random_word[%0d]: got %h expected %h", i, rx_q[i], pix_tab[i % NPIX]);
            end
        end
        n_checks++;
        if (sdata_viol !== 0) begin
            n_fail++;
            $display("FAIL sdata_stable_high: got %0d changes expected 0", sdata_viol);
        end
    endtask

    task automatic test_enable_drop();
        int   k, drop;
        logic last_sclk;
        for (int i = 0; i < NPIX; i++) pix_tab[i] = 16'($urandom);
        drop = $urandom_range(NPIX - 2, W + 1);
        restart();
        enable = 1'b1;
        k = 0;
        while ((int'(y) * W + int'(x)) != drop && k < FRAME) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        k = 0;
        last_sclk = sclk;
        while (busy !== 1'b0 && k < FRAME + 100) begin
            last_sclk = sclk;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_to_idle: busy=%b after %0d cycles expected 0", busy, k);
        end
        n_checks++;
        if ({cs_n, sclk, last_sclk} !== 3'b101) begin
            n_fail++;
            $display("FAIL idle_entry: cs_n/sclk/prev_sclk got %b expected 101",
                     {cs_n, sclk, last_sclk});
        end
        n_checks++;
        if (rx_q.size() !== NPIX) begin
            n_fail++;
            $display("FAIL drop_full_frame: got %0d words expected %0d (drop at %0d)",
                     rx_q.size(), NPIX, drop);
        end
        for (int i = 0; i < rx_q.size() && i < NPIX; i++) begin
            n_checks++;
            if (rx_q[i] !== pix_tab[i]) begin
                n_fail++;
                $display("FAIL drop_word[%0d]: got %h expected %h", i, rx_q[i], pix_tab[i]);
            end
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cs_n !== 1'b1 || fb_q.size() !== 1) begin
            n_fail++;
            $display("FAIL stay_idle: busy=%b cs_n=%b pulses=%0d expected 0 1 1",
                     busy, cs_n, fb_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) pix_tab[i] = '0;
        test_reset();
        test_pattern();
        test_scan_order();
        test_back_to_back();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
